// File: rtl/aq_axi_pkg.sv
// Shared AXI4 codes and slave FSM encoding for the aq_axi SRAM slave.
package aq_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WDATA = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_RPRE  = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;

  // WRAP and the reserved burst code both carry bit 1.
  function automatic logic hdr_bad(input logic [2:0] size, input logic [1:0] burst);
    return (size != AXI_SIZE_8B) || burst[1];
  endfunction

endpackage

// File: rtl/aq_axi_sram64_be.sv
// Single-port synchronous 64-bit RAM with per-byte write enables, 1-cycle read latency.
module aq_axi_sram64_be #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    we,
  input  logic [63:0]   din,
  output logic [63:0]   dout
);

  logic [63:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 8; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= din[i*8 +: 8];
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/aq_axi_slave_sram64.sv
// AXI4 64-bit slave over byte-enabled SRAM; one burst at a time, round-robin AW/AR arbitration.
module aq_axi_slave_sram64
  import aq_axi_pkg::*;
#(
  parameter int unsigned MEM_AW    = 10,
  parameter logic [31:0] BASE_ADRS = 32'h0000_0000
) (
  input  logic        ARESETN,
  input  logic        ACLK,
  input  logic        S_AXI_AWID,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [7:0]  S_AXI_AWLEN,
  input  logic [2:0]  S_AXI_AWSIZE,
  input  logic [1:0]  S_AXI_AWBURST,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [63:0] S_AXI_WDATA,
  input  logic [7:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WLAST,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic        S_AXI_BID,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic        S_AXI_ARID,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [7:0]  S_AXI_ARLEN,
  input  logic [2:0]  S_AXI_ARSIZE,
  input  logic [1:0]  S_AXI_ARBURST,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic        S_AXI_RID,
  output logic [63:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RLAST,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);

  logic [2:0]        state;
  logic              last_wr;
  logic              id_q;
  logic              err_q;
  logic              fixed_q;
  logic [MEM_AW:0]   addr_q;
  logic [MEM_AW:0]   addr_nxt;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;

  logic              idle;
  logic              sel_wr;
  logic              aw_hs;
  logic              ar_hs;
  logic              w_hs;
  logic              r_hs;
  logic              beat_oor;
  logic              last_beat;

  logic [31:0]       a_addr;
  logic [31:0]       a_off;
  logic              a_oor;
  logic [MEM_AW:0]   a_word;
  logic              a_id;
  logic [7:0]        a_len;
  logic [2:0]        a_size;
  logic [1:0]        a_burst;

  logic [MEM_AW-1:0] ram_addr;
  logic [7:0]        ram_we;
  logic [63:0]       ram_dout;
  logic              unused_ok;

  always_comb begin
    idle      = (state == ST_IDLE);
    sel_wr    = S_AXI_AWVALID & (~S_AXI_ARVALID | ~last_wr);
    aw_hs     = idle & S_AXI_AWVALID & sel_wr;
    ar_hs     = idle & S_AXI_ARVALID & ~sel_wr;

    a_addr    = aw_hs ? S_AXI_AWADDR  : S_AXI_ARADDR;
    a_id      = aw_hs ? S_AXI_AWID    : S_AXI_ARID;
    a_len     = aw_hs ? S_AXI_AWLEN   : S_AXI_ARLEN;
    a_size    = aw_hs ? S_AXI_AWSIZE  : S_AXI_ARSIZE;
    a_burst   = aw_hs ? S_AXI_AWBURST : S_AXI_ARBURST;
    a_off     = a_addr - BASE_ADRS;
    // A start outside the window is folded into the word address MSB, which then stays set.
    a_oor     = (a_addr < BASE_ADRS) | (|a_off[31:MEM_AW+3]);
    a_word    = {a_oor, a_off[MEM_AW+2:3]};

    beat_oor  = addr_q[MEM_AW];
    last_beat = (cnt_q == len_q);
    addr_nxt  = (fixed_q | beat_oor) ? addr_q : addr_q + (MEM_AW+1)'(1);

    w_hs      = (state == ST_WDATA) & S_AXI_WVALID;
    r_hs      = (state == ST_RDATA) & S_AXI_RREADY;
    // Prefetch the next beat on an R handshake; otherwise re-read the current one so RDATA holds.
    ram_addr  = r_hs ? addr_nxt[MEM_AW-1:0] : addr_q[MEM_AW-1:0];
    ram_we    = (w_hs & ~beat_oor) ? S_AXI_WSTRB : '0;
  end

  assign unused_ok = ^a_off[2:0];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= ST_IDLE;
      last_wr <= 1'b0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      fixed_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aw_hs | ar_hs) begin
            state   <= aw_hs ? ST_WDATA : ST_RPRE;
            last_wr <= aw_hs;
            id_q    <= a_id;
            addr_q  <= a_word;
            len_q   <= a_len;
            cnt_q   <= '0;
            fixed_q <= (a_burst == AXI_BURST_FIXED);
            err_q   <= hdr_bad(a_size, a_burst);
          end
        end
        ST_WDATA: begin
          if (S_AXI_WVALID) begin
            if (beat_oor || (S_AXI_WLAST != last_beat)) err_q <= 1'b1;
            addr_q <= addr_nxt;
            cnt_q  <= cnt_q + 8'd1;
            if (last_beat) state <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (S_AXI_BREADY) state <= ST_IDLE;
        end
        ST_RPRE: begin
          state <= ST_RDATA;
        end
        ST_RDATA: begin
          if (S_AXI_RREADY) begin
            addr_q <= addr_nxt;
            cnt_q  <= cnt_q + 8'd1;
            if (last_beat) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = aw_hs;
  assign S_AXI_ARREADY = ar_hs;
  assign S_AXI_WREADY  = (state == ST_WDATA);

  assign S_AXI_BVALID  = (state == ST_WRESP);
  assign S_AXI_BID     = S_AXI_BVALID & id_q;
  assign S_AXI_BRESP   = (S_AXI_BVALID & err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

  assign S_AXI_RVALID  = (state == ST_RDATA);
  assign S_AXI_RID     = S_AXI_RVALID & id_q;
  assign S_AXI_RDATA   = (S_AXI_RVALID & ~beat_oor) ? ram_dout : '0;
  assign S_AXI_RRESP   = (S_AXI_RVALID & (err_q | beat_oor)) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign S_AXI_RLAST   = S_AXI_RVALID & last_beat;

  aq_axi_sram64_be #(
    .AW(MEM_AW)
  ) u_sram (
    .clk  (ACLK),
    .addr (ram_addr),
    .we   (ram_we),
    .din  (S_AXI_WDATA),
    .dout (ram_dout)
  );

endmodule

// File: tb/tb_aq_axi_slave_sram64.sv
// Randomized bench for aq_axi_slave_sram64 against a word-array memory model and expected-response queues.
module tb_aq_axi_slave_sram64;
  import aq_axi_pkg::*;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic        ARESETN, ACLK;
  logic        S_AXI_AWID;   logic [31:0] S_AXI_AWADDR; logic [7:0] S_AXI_AWLEN;
  logic [2:0]  S_AXI_AWSIZE; logic [1:0]  S_AXI_AWBURST; logic S_AXI_AWVALID, S_AXI_AWREADY;
  logic [63:0] S_AXI_WDATA;  logic [7:0]  S_AXI_WSTRB;  logic S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic        S_AXI_BID;    logic [1:0]  S_AXI_BRESP;  logic S_AXI_BVALID, S_AXI_BREADY;
  logic        S_AXI_ARID;   logic [31:0] S_AXI_ARADDR; logic [7:0] S_AXI_ARLEN;
  logic [2:0]  S_AXI_ARSIZE; logic [1:0]  S_AXI_ARBURST; logic S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RID;    logic [63:0] S_AXI_RDATA;  logic [1:0] S_AXI_RRESP;
  logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

  aq_axi_slave_sram64 #(.MEM_AW(AW), .BASE_ADRS(BASE)) dut (
    .ARESETN(ARESETN), .ACLK(ACLK),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic id; } rbeat_t;
  typedef struct { logic id; logic [1:0] resp; } bexp_t;

  int          checks = 0;
  int          errors = 0;
  rbeat_t      exp_r[$];
  bexp_t       exp_b[$];
  logic [63:0] got_data[$];
  logic [1:0]  got_resp[$];
  logic        got_last[$];
  logic [1:0]  last_bresp;
  logic        last_bid;
  logic [63:0] mdl [0:DEPTH-1];
  logic        last_dir_wr;
  logic [63:0] wd[$];
  logic [7:0]  ws[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  task automatic beat_loc(input logic [31:0] addr, input int i, input logic [1:0] burst,
                          output logic inr, output int unsigned w);
    longint unsigned a;
    a = 64'(addr & 32'hFFFF_FFF8);
    if (burst != AXI_BURST_FIXED) a += 64'(i) * 8;
    inr = (a >= 64'(BASE)) && (a < 64'(BASE) + 64'(8 * DEPTH));
    w = inr ? 32'((a - 64'(BASE)) >> 3) : 0;
  endtask

  function automatic logic bad_header(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'd3) || (burst == 2'b10) || (burst == 2'b11);
  endfunction

  function automatic logic wlast_of(input int i, input int len, input int bad_beat);
    return (i == len) ^ (i == bad_beat);
  endfunction

  task automatic model_write(input logic id, input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst, input int bad_beat);
    logic err, inr; int unsigned w; bexp_t e;
    err = bad_header(size, burst);
    for (int i = 0; i <= len; i++) begin
      beat_loc(addr, i, burst, inr, w);
      if (inr) begin
        for (int k = 0; k < 8; k++) if (ws[i][k]) mdl[w][k*8 +: 8] = wd[i][k*8 +: 8];
      end else begin
        err = 1'b1;
      end
      if (wlast_of(i, len, bad_beat) != (i == len)) err = 1'b1;
    end
    e.id = id; e.resp = err ? 2'b10 : 2'b00;
    exp_b.push_back(e);
  endtask

  task automatic model_read(input logic id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic inr; int unsigned w; rbeat_t e;
    for (int i = 0; i <= len; i++) begin
      beat_loc(addr, i, burst, inr, w);
      e.data = inr ? mdl[w] : 64'h0;
      e.resp = (bad_header(size, burst) || !inr) ? 2'b10 : 2'b00;
      e.last = (i == len);
      e.id   = id;
      exp_r.push_back(e);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (S_AXI_RVALID) begin
        if (exp_r.size() == 0) chk("r_unexpected", S_AXI_RVALID, 0);
        else begin
          chk("rdata", S_AXI_RDATA, exp_r[0].data);
          chk("rresp", S_AXI_RRESP, exp_r[0].resp);
          chk("rlast", S_AXI_RLAST, exp_r[0].last);
          chk("rid",   S_AXI_RID,   exp_r[0].id);
          if (S_AXI_RREADY) begin
            got_data.push_back(S_AXI_RDATA);
            got_resp.push_back(S_AXI_RRESP);
            got_last.push_back(S_AXI_RLAST);
            void'(exp_r.pop_front());
          end
        end
      end
      if (S_AXI_BVALID) begin
        if (exp_b.size() == 0) chk("b_unexpected", S_AXI_BVALID, 0);
        else begin
          chk("bresp", S_AXI_BRESP, exp_b[0].resp);
          chk("bid",   S_AXI_BID,   exp_b[0].id);
          if (S_AXI_BREADY) begin
            last_bresp = S_AXI_BRESP;
            last_bid   = S_AXI_BID;
            void'(exp_b.pop_front());
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic aw_drive(input logic id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst);
    S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len);
    S_AXI_AWSIZE = size; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
  endtask

  task automatic ar_drive(input logic id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst);
    S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len);
    S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
  endtask

  task automatic aw_wait();
    logic ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY) begin
        @(posedge ACLK); #1;
        ok = 1'b1; last_dir_wr = 1'b1;
      end
    end
    S_AXI_AWVALID = 1'b0;
    chk("aw_timeout", ok, 1);
  endtask

  task automatic ar_wait();
    logic ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge ACLK);
      if (S_AXI_ARREADY) begin
        @(posedge ACLK); #1;
        ok = 1'b1; last_dir_wr = 1'b0;
      end
    end
    S_AXI_ARVALID = 1'b0;
    chk("ar_timeout", ok, 1);
  endtask

  task automatic w_phase(input int len, input int bad_beat, input logic gaps);
    logic ok = 1'b1;
    for (int i = 0; i <= len && ok; i++) begin
      if (gaps && ($urandom % 4 == 0)) begin
        S_AXI_WVALID = 1'b0;
        repeat ($urandom_range(1, 2)) begin @(posedge ACLK); #1; end
      end
      S_AXI_WVALID = 1'b1; S_AXI_WDATA = wd[i]; S_AXI_WSTRB = ws[i];
      S_AXI_WLAST = wlast_of(i, len, bad_beat);
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
        @(negedge ACLK);
        ok = S_AXI_WREADY;
        @(posedge ACLK); #1;
      end
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    chk("w_timeout", ok, 1);
  endtask

  task automatic b_phase(input logic rnd);
    logic ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      S_AXI_BREADY = rnd ? 1'($urandom % 2) : 1'b1;
      @(negedge ACLK);
      ok = S_AXI_BVALID && S_AXI_BREADY;
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1'b0;
    chk("b_timeout", ok, 1);
  endtask

  task automatic r_phase(input int len, input int mode, input int abort_after);
    int n = 0; logic ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      case (mode)
        0:       S_AXI_RREADY = 1'b1;
        1:       S_AXI_RREADY = (c % 3 == 0);
        default: S_AXI_RREADY = 1'($urandom % 2);
      endcase
      @(negedge ACLK);
      if (S_AXI_RVALID && S_AXI_RREADY) n++;
      @(posedge ACLK); #1;
      if (n == len + 1) ok = 1'b1;
      else if (n == abort_after) begin
        ARESETN = 1'b0;
        exp_r.delete();
        ok = 1'b1;
      end
    end
    S_AXI_RREADY = 1'b0;
    chk("r_timeout", ok, 1);
  endtask

  task automatic wr_txn(input logic id, input logic [31:0] addr, input int len, input logic [2:0] size,
                        input logic [1:0] burst, input int bad_beat, input logic rnd);
    model_write(id, addr, len, size, burst, bad_beat);
    aw_drive(id, addr, len, size, burst);
    aw_wait();
    w_phase(len, bad_beat, rnd);
    b_phase(rnd);
  endtask

  task automatic rd_txn(input logic id, input logic [31:0] addr, input int len, input logic [2:0] size,
                        input logic [1:0] burst, input int mode);
    model_read(id, addr, len, size, burst);
    ar_drive(id, addr, len, size, burst);
    ar_wait();
    r_phase(len, mode, -1);
  endtask

  task automatic fill_wd(input int n, input logic full_strb);
    wd.delete(); ws.delete();
    for (int i = 0; i < n; i++) begin
      wd.push_back({$urandom, $urandom});
      ws.push_back(full_strb ? 8'hFF : 8'($urandom));
    end
  endtask

  // AW and AR raised together; the winner is predicted from which direction went last.
  task automatic both_txn(input logic [31:0] waddr, input int wlen, input logic [31:0] raddr,
                          input int rlen, output logic won_wr);
    logic got = 1'b0, exp_wr;
    won_wr = 1'b0;
    exp_wr = !last_dir_wr;
    aw_drive(1'b1, waddr, wlen, 3'd3, AXI_BURST_INCR);
    ar_drive(1'b0, raddr, rlen, 3'd3, AXI_BURST_INCR);
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY || S_AXI_ARREADY) begin
        got = 1'b1; won_wr = S_AXI_AWREADY;
        chk("arb_onehot", S_AXI_AWREADY & S_AXI_ARREADY, 0);
      end
    end
    chk("arb_timeout", got, 1);
    chk("arb_winner", won_wr, exp_wr);
    if (!got) begin
      S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    end else if (won_wr) begin
      model_write(1'b1, waddr, wlen, 3'd3, AXI_BURST_INCR, -1);
      @(posedge ACLK); #1; S_AXI_AWVALID = 1'b0; last_dir_wr = 1'b1;
      w_phase(wlen, -1, 1'b0); b_phase(1'b0);
      model_read(1'b0, raddr, rlen, 3'd3, AXI_BURST_INCR);
      ar_wait(); r_phase(rlen, 0, -1);
    end else begin
      model_read(1'b0, raddr, rlen, 3'd3, AXI_BURST_INCR);
      @(posedge ACLK); #1; S_AXI_ARVALID = 1'b0; last_dir_wr = 1'b0;
      r_phase(rlen, 0, -1);
      model_write(1'b1, waddr, wlen, 3'd3, AXI_BURST_INCR, -1);
      aw_wait(); w_phase(wlen, -1, 1'b0); b_phase(1'b0);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    chk(name, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BID, S_AXI_BRESP,
               S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RID, S_AXI_RRESP, S_AXI_RLAST}, 0);
    chk({name, "_rdata"}, S_AXI_RDATA, 0);
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic won;
    logic [7:0] vec;
    logic [31:0] addr;
    int len, mode, sel;
    logic [2:0] size;
    logic [1:0] burst;

    ARESETN = 1'b0; last_dir_wr = 1'b0;
    S_AXI_AWID = 0; S_AXI_AWADDR = 0; S_AXI_AWLEN = 0; S_AXI_AWSIZE = 0; S_AXI_AWBURST = 0;
    S_AXI_AWVALID = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WLAST = 0; S_AXI_WVALID = 0;
    S_AXI_BREADY = 0; S_AXI_ARID = 0; S_AXI_ARADDR = 0; S_AXI_ARLEN = 0; S_AXI_ARSIZE = 0;
    S_AXI_ARBURST = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK); check_outputs_zero("reset_outs");
    @(posedge ACLK); #1; ARESETN = 1'b1;

    // Simultaneous AW/AR straight out of reset: write goes first.
    fill_wd(2, 1'b1);
    both_txn(BASE + 32'h40, 1, BASE + 32'h40, 1, won);
    chk("t4_first_is_write", won, 1);

    // Known contents everywhere, using maximum-length bursts.
    for (int k = 0; k < 4; k++) begin
      fill_wd(256, 1'b1);
      wr_txn(1'($urandom), BASE + 32'(k * 2048), 255, 3'd3, AXI_BURST_INCR, -1, 1'b0);
    end

    // Last served was a write, so the read now wins.
    fill_wd(1, 1'b1);
    both_txn(BASE + 32'h80, 0, BASE + 32'h40, 1, won);
    chk("t4_second_is_read", won, 0);

    // Basic INCR write then readback.
    wd = '{64'd1, 64'd2, 64'd3, 64'd4}; ws = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    wr_txn(1'b1, BASE + 32'h100, 3, 3'd3, AXI_BURST_INCR, -1, 1'b0);
    chk("t1_bresp", last_bresp, 2'b00);
    chk("t1_bid", last_bid, 1);
    got_data.delete(); got_resp.delete(); got_last.delete();
    rd_txn(1'b0, BASE + 32'h100, 3, 3'd3, AXI_BURST_INCR, 0);
    chk("t1_count", got_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_data", got_data[i], 64'(i + 1));
      chk("t1_last", got_last[i], (i == 3));
      chk("t1_resp", got_resp[i], 2'b00);
    end

    // Partial byte strobes merge with existing contents.
    wd = '{64'hFFFF_FFFF_FFFF_FFFF}; ws = '{8'hFF};
    wr_txn(1'b0, BASE, 0, 3'd3, AXI_BURST_INCR, -1, 1'b0);
    wd = '{64'h1122_3344_5566_7788}; ws = '{8'h0F};
    wr_txn(1'b0, BASE, 0, 3'd3, AXI_BURST_INCR, -1, 1'b0);
    got_data.delete(); got_resp.delete(); got_last.delete();
    rd_txn(1'b0, BASE, 0, 3'd3, AXI_BURST_INCR, 0);
    chk("t2_data", got_data[0], 64'hFFFF_FFFF_5566_7788);

    // Stalled read, RREADY 1,0,0 repeating.
    got_data.delete(); got_resp.delete(); got_last.delete();
    rd_txn(1'b1, BASE + 32'h200, 7, 3'd3, AXI_BURST_INCR, 1);
    chk("t3_count", got_data.size(), 8);
    vec = '0;
    for (int i = 0; i < 8 && i < got_last.size(); i++) vec[i] = got_last[i];
    chk("t3_last_vec", vec, 8'h80);

    // Burst starting on the last word runs off the top of the window.
    addr = BASE + 32'(8 * (DEPTH - 1));
    fill_wd(4, 1'b1);
    wr_txn(1'b0, addr, 3, 3'd3, AXI_BURST_INCR, -1, 1'b0);
    chk("t5_bresp", last_bresp, 2'b10);
    got_data.delete(); got_resp.delete(); got_last.delete();
    rd_txn(1'b0, addr, 3, 3'd3, AXI_BURST_INCR, 0);
    vec = '0;
    for (int i = 0; i < 4 && i < got_resp.size(); i++) vec[i*2 +: 2] = got_resp[i];
    chk("t5_resp_vec", vec, 8'hA8);
    for (int i = 1; i < 4; i++) chk("t5_oor_data", got_data[i], 64'h0);
    rd_txn(1'b0, BASE, 2, 3'd3, AXI_BURST_INCR, 0);
    rd_txn(1'b1, BASE - 32'd8, 0, 3'd3, AXI_BURST_INCR, 0);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      addr  = BASE + 32'(8 * $urandom_range(0, DEPTH + 20)) + 32'($urandom_range(0, 7));
      len   = ($urandom % 8 == 0) ? $urandom_range(0, 40) : $urandom_range(0, 7);
      size  = ($urandom % 10 == 0) ? 3'($urandom_range(0, 2)) : 3'd3;
      sel   = $urandom % 10;
      burst = (sel < 6) ? AXI_BURST_INCR : (sel < 8) ? AXI_BURST_FIXED : (sel < 9) ? AXI_BURST_WRAP : 2'b11;
      mode  = $urandom_range(0, 2);
      if ($urandom % 2) begin
        fill_wd(len + 1, 1'($urandom % 2));
        wr_txn(1'($urandom), addr, len, size, burst, ($urandom % 8 == 0) ? $urandom_range(0, len) : -1, 1'b1);
      end else begin
        rd_txn(1'($urandom), addr, len, size, burst, mode);
      end
    end

    // Early WLAST is an error but the burst length still comes from LEN.
    fill_wd(4, 1'b1);
    wr_txn(1'b1, BASE + 32'h300, 3, 3'd3, AXI_BURST_INCR, 1, 1'b0);
    chk("t6_bresp", last_bresp, 2'b10);
    rd_txn(1'b1, BASE + 32'h300, 3, 3'd3, AXI_BURST_INCR, 0);

    // Reset while the second beat of a read is on the bus.
    model_read(1'b1, BASE + 32'h300, 7, 3'd3, AXI_BURST_INCR);
    ar_drive(1'b1, BASE + 32'h300, 7, 3'd3, AXI_BURST_INCR);
    ar_wait();
    r_phase(7, 0, 1);
    @(negedge ACLK); check_outputs_zero("t6_reset_outs");
    @(posedge ACLK); #1; ARESETN = 1'b1; last_dir_wr = 1'b0;
    fill_wd(1, 1'b1);
    both_txn(BASE + 32'h380, 0, BASE + 32'h300, 3, won);
    chk("t6_arb_after_reset", won, 1);
    rd_txn(1'b0, BASE + 32'h380, 0, 3'd3, AXI_BURST_INCR, 2);

    repeat (4) @(posedge ACLK);
    chk("exp_r_drained", exp_r.size(), 0);
    chk("exp_b_drained", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
